// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready streaming,
// RNE/RTZ rounding, exception flags and a pass-through tag.
module fp_mul_pipe #(
  parameter int BITS          = 32,
  parameter int MANTISSA_BITS = 23,
  parameter int EXPONENT_BITS = 8,
  parameter int TAG_BITS      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     x,
  input  logic [BITS-1:0]     y,
  input  logic                rnd_mode,
  input  logic [TAG_BITS-1:0] in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITS-1:0]     out,
  output logic [3:0]          flags,
  output logic [TAG_BITS-1:0] out_tag
);
  localparam int M  = MANTISSA_BITS;
  localparam int E  = EXPONENT_BITS;
  localparam int EW = E + 2;
  localparam int PW = 2 * M + 2;
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (E - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << E) - 2);
  localparam logic signed [EW-1:0] EXP_MIN = EW'(1);
  localparam logic [M-1:0]         QNAN_FRAC = {1'b1, {(M - 1){1'b0}}};

  // Handshake: a stage transfer happens on every cycle where the output slot
  // is empty or being consumed; in_ready = advance; accept = in_valid & in_ready.
  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // ---------------- S1: unpack and classify ----------------
  logic          sx, sy;
  logic [E-1:0]  ex, ey;
  logic [M-1:0]  fx, fy;
  logic          x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;
  logic          inf_zero, c_nan, c_inf, c_zero, c_invalid;
  logic signed [EW-1:0] exp_sum;

  assign {sx, ex, fx} = x;
  assign {sy, ey, fy} = y;
  // Zero exponent covers denormals too: they are flushed to signed zero.
  assign x_zero   = (ex == '0);
  assign y_zero   = (ey == '0);
  assign x_inf    = (&ex) & (fx == '0);
  assign y_inf    = (&ey) & (fy == '0);
  assign x_nan    = (&ex) & (fx != '0);
  assign y_nan    = (&ey) & (fy != '0);
  assign x_snan   = x_nan & ~fx[M-1];
  assign y_snan   = y_nan & ~fy[M-1];
  assign inf_zero = (x_inf & y_zero) | (y_inf & x_zero);
  assign c_nan     = x_nan | y_nan | inf_zero;
  assign c_invalid = x_snan | y_snan | inf_zero;
  assign c_inf     = ~c_nan & (x_inf | y_inf);
  assign c_zero    = ~c_nan & ~c_inf & (x_zero | y_zero);
  assign exp_sum   = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS;

  logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero, s1_invalid, s1_rtz;
  logic signed [EW-1:0] s1_exp;
  logic [M:0]           s1_ma, s1_mb;
  logic [TAG_BITS-1:0]  s1_tag;

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign    <= sx ^ sy;
      s1_exp     <= exp_sum;
      s1_ma      <= {1'b1, fx};
      s1_mb      <= {1'b1, fy};
      s1_nan     <= c_nan;
      s1_inf     <= c_inf;
      s1_zero    <= c_zero;
      s1_invalid <= c_invalid;
      s1_rtz     <= rnd_mode;
      s1_tag     <= in_tag;
    end
  end

  // ---------------- S2: significand product ----------------
  logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero, s2_invalid, s2_rtz;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;
  logic [TAG_BITS-1:0]  s2_tag;

  always_ff @(posedge clk) begin
    if (advance) begin
      s2_sign    <= s1_sign;
      s2_exp     <= s1_exp;
      s2_prod    <= PW'(s1_ma) * PW'(s1_mb);
      s2_nan     <= s1_nan;
      s2_inf     <= s1_inf;
      s2_zero    <= s1_zero;
      s2_invalid <= s1_invalid;
      s2_rtz     <= s1_rtz;
      s2_tag     <= s1_tag;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic                 prod_msb, g, r, sticky, inc, inexact;
  logic [PW-2:0]        norm;
  logic [M-1:0]         mant;
  logic [M:0]           mant_r;
  logic signed [EW-1:0] exp_n, exp_r;
  logic [BITS-1:0]      res;
  logic [3:0]           res_flags;

  // Left-justify the product so the hidden bit sits just above norm's MSB.
  assign prod_msb = s2_prod[PW-1];
  assign norm     = prod_msb ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
  assign mant     = norm[PW-2 -: M];
  assign g        = norm[M];
  assign r        = norm[M-1];
  assign sticky   = |norm[M-2:0];
  assign inexact  = g | r | sticky;
  assign inc      = ~s2_rtz & g & (r | sticky | mant[0]);
  assign mant_r   = {1'b0, mant} + (M + 1)'(inc);
  assign exp_n    = s2_exp + $signed({{(EW - 1){1'b0}}, prod_msb});
  assign exp_r    = exp_n + $signed({{(EW - 1){1'b0}}, mant_r[M]});

  always_comb begin
    res       = '0;
    res_flags = '0;
    if (s2_nan) begin
      res       = {1'b0, {E{1'b1}}, QNAN_FRAC};
      res_flags = {s2_invalid, 3'b000};
    end else if (s2_inf) begin
      res = {s2_sign, {E{1'b1}}, {M{1'b0}}};
    end else if (s2_zero) begin
      res = {s2_sign, {(BITS - 1){1'b0}}};
    end else if (exp_r > EXP_MAX) begin
      res_flags = 4'b0101;
      res = s2_rtz ? {s2_sign, {(E - 1){1'b1}}, 1'b0, {M{1'b1}}}
                   : {s2_sign, {E{1'b1}}, {M{1'b0}}};
    end else if (exp_r < EXP_MIN) begin
      res_flags = 4'b0011;
      res       = {s2_sign, {(BITS - 1){1'b0}}};
    end else begin
      res_flags = {3'b000, inexact};
      res       = {s2_sign, exp_r[E-1:0], mant_r[M-1:0]};
    end
  end

  // Valid bits and visible outputs are the only reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out       <= res;
      flags     <= res_flags;
      out_tag   <= s2_tag;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (binary32): directed spec vectors, back-pressure,
// mid-flight reset and randomized traffic against an arithmetic reference.
module tb_fp_mul_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        rnd_mode = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic [3:0]  flags;
  logic [3:0]  out_tag;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          rand_ready = 1'b0;
  logic [39:0] exp_q[$];

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .rnd_mode(rnd_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .flags(flags), .out_tag(out_tag)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Exact integer product, then rounded to 24 significant bits by comparing
  // the discarded remainder with one half ulp. Returns {result, flags}.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic rtz);
    logic        s;
    int          ea, eb, e, n, shift;
    logic [22:0] fa, fb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, infz, sn;
    logic [63:0] p, q, rem, half, one;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    nan_a = (ea == 255) && (fa != 0); nan_b = (eb == 255) && (fb != 0);
    inf_a = (ea == 255) && (fa == 0); inf_b = (eb == 255) && (fb == 0);
    zero_a = (ea == 0); zero_b = (eb == 0);
    infz = (inf_a && zero_b) || (inf_b && zero_a);
    sn = (nan_a && !fa[22]) || (nan_b && !fb[22]);
    if (nan_a || nan_b || infz) return {32'h7FC00000, (sn || infz), 3'b000};
    if (inf_a || inf_b) return {s, 8'hFF, 23'd0, 4'b0000};
    if (zero_a || zero_b) return {s, 31'd0, 4'b0000};
    p = 64'({1'b1, fa}) * 64'({1'b1, fb});
    n = p[47] ? 47 : 46;
    shift = n - 23;
    one = 64'd1;
    q = p >> shift;
    rem = p & ((one << shift) - one);
    half = one << (shift - 1);
    e = ea + eb - 127 + (n - 46);
    if (!rtz && ((rem > half) || (rem == half && q[0]))) q = q + one;
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e > 254) return rtz ? {s, 8'hFE, 23'h7FFFFF, 4'b0101} : {s, 8'hFF, 23'd0, 4'b0101};
    if (e < 1) return {s, 31'd0, 4'b0011};
    return {s, 8'(e), q[22:0], 3'b000, (rem != 0)};
  endfunction

  function automatic logic [31:0] gen_op();
    logic        s;
    logic [22:0] f;
    int          k;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    k = $urandom_range(0, 11);
    if (k <= 4) return {s, 8'($urandom_range(100, 154)), f};
    else if (k == 5) return {s, 8'($urandom_range(120, 134)), 20'hFFFFF, 3'($urandom)};
    else if (k == 6) return $urandom;
    else if (k == 7) return {s, 8'd0, ($urandom_range(0, 1) == 1) ? f : 23'd0};
    else if (k == 8) return {s, 8'hFF, 23'd0};
    else if (k == 9) return {s, 8'hFF, (f == 0) ? 23'd1 : f};
    else if (k == 10) return {s, 8'($urandom_range(1, 20)), f};
    return {s, 8'($urandom_range(230, 254)), f};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  // with in_valid still high so ops can follow back to back.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic rm,
                      input logic [3:0] t, input bit use_const, input logic [35:0] cexp);
    int          guard = 0;
    logic [35:0] e;
    in_valid = 1'b1; x = a; y = b; rnd_mode = rm; in_tag = t;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for tag %0d", t);
    end else begin
      e = use_const ? cexp : ref_mul(a, b, rm);
      exp_q.push_back({e, t});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d results never delivered", exp_q.size());
    end
  endtask

  task automatic latency_check(input string name);
    int lat = 1;
    in_valid = 1'b0;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    check(name, 64'(lat), 64'd3);
  endtask

  // ---------------- ready driver and scoreboard monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial forever begin
    @(negedge clk); #2;
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_result: got %h/%b tag %0d with empty queue", out, flags, out_tag);
      end else begin
        check("result {out,flags,tag}", 64'({out, flags, out_tag}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [31:0] da[14], db[14];
  logic        dr[14];
  logic [35:0] de[14];

  initial begin
    da[0]  = 32'h7F800000; db[0]  = 32'h00000000; dr[0]  = 0; de[0]  = {32'h7FC00000, 4'b1000};
    da[1]  = 32'h7F800000; db[1]  = 32'hC0000000; dr[1]  = 0; de[1]  = {32'hFF800000, 4'b0000};
    da[2]  = 32'h7F7FFFFF; db[2]  = 32'h40000000; dr[2]  = 0; de[2]  = {32'h7F800000, 4'b0101};
    da[3]  = 32'h7F7FFFFF; db[3]  = 32'h40000000; dr[3]  = 1; de[3]  = {32'h7F7FFFFF, 4'b0101};
    da[4]  = 32'h00800000; db[4]  = 32'h3F000000; dr[4]  = 0; de[4]  = {32'h00000000, 4'b0011};
    da[5]  = 32'h3F800001; db[5]  = 32'h3F800001; dr[5]  = 0; de[5]  = {32'h3F800002, 4'b0001};
    da[6]  = 32'h3F800001; db[6]  = 32'h3FC00000; dr[6]  = 0; de[6]  = {32'h3FC00002, 4'b0001};
    da[7]  = 32'h3F800001; db[7]  = 32'h3FC00000; dr[7]  = 1; de[7]  = {32'h3FC00001, 4'b0001};
    da[8]  = 32'h7FC00001; db[8]  = 32'h3F800000; dr[8]  = 0; de[8]  = {32'h7FC00000, 4'b0000};
    da[9]  = 32'h7F800001; db[9]  = 32'h3F800000; dr[9]  = 0; de[9]  = {32'h7FC00000, 4'b1000};
    da[10] = 32'h00000001; db[10] = 32'hBF800000; dr[10] = 0; de[10] = {32'h80000000, 4'b0000};
    da[11] = 32'h00800000; db[11] = 32'h3F800000; dr[11] = 0; de[11] = {32'h00800000, 4'b0000};
    da[12] = 32'hC0400000; db[12] = 32'h40000000; dr[12] = 1; de[12] = {32'hC0C00000, 4'b0000};
    da[13] = 32'h7F800000; db[13] = 32'hFF800001; dr[13] = 0; de[13] = {32'h7FC00000, 4'b1000};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out", 64'(out), 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    check("reset out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready after reset", 64'(in_ready), 64'd1);
    @(negedge clk);

    // 1.0 * 1.0 with latency measurement
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'd5, 1'b1, {32'h3F800000, 4'b0000});
    latency_check("latency 1.0*1.0");
    drain();

    // Directed specials, overflow, underflow, rounding; model cross-checked too
    for (int i = 0; i < 14; i++) begin
      check($sformatf("model vector %0d", i), 64'(ref_mul(da[i], db[i], dr[i])), 64'(de[i]));
      send(da[i], db[i], dr[i], 4'(i), 1'b1, de[i]);
    end
    drain();

    // Back-pressure: six back-to-back ops, consumer stalls five cycles
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++)
          send({1'b0, 8'($urandom_range(110, 140)), 23'($urandom)},
               {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)},
               1'($urandom_range(0, 1)), 4'(i + 8), 1'b0, '0);
        in_valid = 1'b0;
      end
      begin
        logic [39:0] held;
        int          g = 0;
        while (!out_valid && g < 50) begin
          @(negedge clk);
          g++;
        end
        if (!out_valid) begin
          n_checks++; n_fail++;
          $display("FAIL stall_start: out_valid never rose");
        end
        out_ready = 1'b0;
        held = {out, flags, out_tag};
        for (int i = 0; i < 5; i++) begin
          #1;
          check("stall in_ready", 64'(in_ready), 64'd0);
          if (i > 0) check("stall hold", 64'({out, flags, out_tag}), 64'(held));
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++)
      send({1'b0, 8'($urandom_range(110, 140)), 23'($urandom)},
           {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)}, 1'b0, 4'(i + 1), 1'b0, '0);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset out_valid", 64'(out_valid), 64'd0);
    check("post-reset in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("no stale output", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    send(32'h40400000, 32'h40000000, 1'b0, 4'd9, 1'b1, {32'h40C00000, 4'b0000});
    latency_check("latency after reset");
    drain();

    // Randomized traffic with random in_valid gaps and out_ready
    rand_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end else begin
        send(gen_op(), gen_op(), 1'($urandom_range(0, 1)), 4'($urandom), 1'b0, '0);
      end
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
